// File: rtl/nf_flash_ctrl_pkg.sv
// nf_flash_ctrl_pkg: shared FSM state encoding, NF_BYTE mode constants and sizing helper
package nf_flash_ctrl_pkg;
    typedef enum logic [2:0] {
        ST_RST, ST_IDLE, ST_SETUP, ST_PULSE, ST_HOLD, ST_BLANK, ST_WAIT, ST_RESP
    } state_t;
    localparam logic BYTE_MODE = 1'b0;
    localparam logic WORD_MODE = 1'b1;
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/nf_flash_ctrl_if.sv
// nf_flash_ctrl_if: user-side request/response bus of the flash controller
//   master: cmd_valid, cmd_write, cmd_addr, cmd_wdata, wp_unlock out; cmd_ready, rsp_* in
//   slave : the mirror image, used by nf_flash_ctrl
interface nf_flash_ctrl_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 8
) ();
    import nf_flash_ctrl_pkg::*;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              wp_unlock;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_timeout;
    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, wp_unlock,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_timeout
    );
    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, wp_unlock,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_timeout
    );
endinterface

// File: rtl/nf_flash_ctrl_sts_sync.sv
// nf_sts_sync: 2-flop synchroniser for the asynchronous NF_STS pin
//   clk, rst_n : clock, async active-low reset (clears to 0 = busy)
//   d          : asynchronous input
//   q          : synchronised output
module nf_sts_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {q, meta} <= 2'b00;
        else        {q, meta} <= {meta, d};
endmodule

// File: rtl/nf_flash_ctrl.sv
// nf_flash_ctrl: timed CE/OE/WE controller for a parallel NOR flash with optional STS wait
//   clk, rst_n          : clock, async active-low reset
//   bus (slave)         : cmd_valid/ready/write/addr/wdata, wp_unlock, rsp_valid/rdata/timeout
//   NF_A, NF_D          : flash address, bidirectional data (driven only during writes)
//   NF_CE, NF_OE, NF_WE : active-low strobes, all straight from flops
//   NF_BYTE, NF_RP, NF_WP : mode pin, active-low flash reset, write-protect release
//   NF_STS              : asynchronous ready/busy from flash (1 = ready)
module nf_flash_ctrl import nf_flash_ctrl_pkg::*; #(
    parameter int ADDR_W      = 24,
    parameter int DATA_W      = 8,
    parameter int T_SETUP     = 2,
    parameter int T_PULSE     = 4,
    parameter int T_HOLD      = 2,
    parameter int T_RP        = 8,
    parameter int STS_WAIT    = 1,
    parameter int STS_BLANK   = 3,
    parameter int STS_TIMEOUT = 4096
) (
    input  logic               clk,
    input  logic               rst_n,
    nf_flash_ctrl_if.slave     bus,
    output logic [ADDR_W-1:0]  NF_A,
    inout  wire  [DATA_W-1:0]  NF_D,
    output logic               NF_CE,
    output logic               NF_OE,
    output logic               NF_WE,
    output logic               NF_BYTE,
    output logic               NF_RP,
    output logic               NF_WP,
    input  logic               NF_STS
);
    localparam int PH_MAX = max2(max2(T_SETUP, T_PULSE), max2(max2(T_HOLD, T_RP), STS_BLANK));
    localparam int PW     = $clog2(PH_MAX + 1);
    localparam int TW     = $clog2(STS_TIMEOUT + 1);

    state_t            state;
    logic [PW-1:0]     ph;
    logic [PW-1:0]     ph_last;
    logic              ph_done;
    logic [TW-1:0]     tc;
    logic              wr;
    logic              drive;
    logic [DATA_W-1:0] wdata;
    logic              sts;

    nf_sts_sync u_sync (.clk(clk), .rst_n(rst_n), .d(NF_STS), .q(sts));

    assign NF_D    = drive ? wdata : 'z;
    assign NF_BYTE = (DATA_W == 16) ? WORD_MODE : BYTE_MODE;

    // One shared phase counter; its terminal count depends on the timed state.
    always_comb begin
        ph_last = state == ST_RST   ? PW'(T_RP - 1)    :
                  state == ST_SETUP ? PW'(T_SETUP - 1) :
                  state == ST_PULSE ? PW'(T_PULSE - 1) :
                  state == ST_HOLD  ? PW'(T_HOLD - 1)  : PW'(STS_BLANK - 1);
        ph_done = ph == ph_last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_RST;
            ph              <= '0;
            tc              <= '0;
            wr              <= 1'b0;
            drive           <= 1'b0;
            wdata           <= '0;
            NF_A            <= '0;
            NF_CE           <= 1'b1;
            NF_OE           <= 1'b1;
            NF_WE           <= 1'b1;
            NF_RP           <= 1'b0;
            NF_WP           <= 1'b0;
            bus.cmd_ready   <= 1'b0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_rdata   <= '0;
            bus.rsp_timeout <= 1'b0;
        end else begin
            NF_WP         <= bus.wp_unlock;
            bus.rsp_valid <= 1'b0;
            if (state inside {ST_RST, ST_SETUP, ST_PULSE, ST_HOLD, ST_BLANK})
                ph <= ph_done ? '0 : ph + 1'b1;
            case (state)
                ST_RST: if (ph_done) begin
                    NF_RP         <= 1'b1;
                    bus.cmd_ready <= 1'b1;
                    state         <= ST_IDLE;
                end
                ST_IDLE: if (bus.cmd_valid && bus.cmd_ready) begin
                    bus.cmd_ready <= 1'b0;
                    wr            <= bus.cmd_write;
                    wdata         <= bus.cmd_wdata;
                    NF_A          <= bus.cmd_addr;
                    drive         <= bus.cmd_write;
                    NF_CE         <= 1'b0;
                    state         <= ST_SETUP;
                end
                ST_SETUP: if (ph_done) begin
                    NF_OE <= wr;
                    NF_WE <= !wr;
                    state <= ST_PULSE;
                end
                // Read data is captured while OE is still low, before the strobe rises.
                ST_PULSE: if (ph_done) begin
                    NF_OE <= 1'b1;
                    NF_WE <= 1'b1;
                    if (!wr) bus.rsp_rdata <= NF_D;
                    state <= ST_HOLD;
                end
                ST_HOLD: if (ph_done) begin
                    NF_CE           <= 1'b1;
                    drive           <= 1'b0;
                    bus.rsp_timeout <= 1'b0;
                    state           <= (wr && STS_WAIT != 0) ? ST_BLANK : ST_RESP;
                end
                // STS may lag WE; ignore it until the blanking window has elapsed.
                ST_BLANK: if (ph_done) begin
                    tc    <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    tc <= tc + 1'b1;
                    if (sts) state <= ST_RESP;
                    else if (tc == TW'(STS_TIMEOUT - 1)) begin
                        bus.rsp_timeout <= 1'b1;
                        state           <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    bus.rsp_valid <= 1'b1;
                    bus.cmd_ready <= 1'b1;
                    state         <= ST_IDLE;
                end
                default: state <= ST_RST;
            endcase
        end
    end
endmodule

// File: tb/tb_nf_flash_ctrl.sv
// tb_nf_flash_ctrl: directed and randomized checks of nf_flash_ctrl (8-bit with STS wait, 16-bit without)
module tb_nf_flash_ctrl;
    localparam int TS = 2, TP = 4, TH = 2, TRP = 8, TBL = 3, TTO = 4096;
    localparam int RD_LAT = TS + TP + TH + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    nf_flash_ctrl_if #(.ADDR_W(24), .DATA_W(8))  b8 ();
    nf_flash_ctrl_if #(.ADDR_W(24), .DATA_W(16)) b16 ();

    logic [23:0] a8, a16;
    wire  [7:0]  d8;
    wire  [15:0] d16;
    logic ce8, oe8, we8, byte8, rp8, wp8, sts8;
    logic ce16, oe16, we16, byte16, rp16, wp16;

    nf_flash_ctrl #(.ADDR_W(24), .DATA_W(8), .STS_WAIT(1)) u8 (
        .clk(clk), .rst_n(rst_n), .bus(b8), .NF_A(a8), .NF_D(d8), .NF_CE(ce8), .NF_OE(oe8),
        .NF_WE(we8), .NF_BYTE(byte8), .NF_RP(rp8), .NF_WP(wp8), .NF_STS(sts8)
    );
    nf_flash_ctrl #(.ADDR_W(24), .DATA_W(16), .STS_WAIT(0)) u16 (
        .clk(clk), .rst_n(rst_n), .bus(b16), .NF_A(a16), .NF_D(d16), .NF_CE(ce16), .NF_OE(oe16),
        .NF_WE(we16), .NF_BYTE(byte16), .NF_RP(rp16), .NF_WP(wp16), .NF_STS(1'b0)
    );

    // Bus-level flash models: erased to all-ones, program on WE rise, busy 20 cycles after a program.
    logic [7:0]  fm8  [256] = '{default: 8'hFF};
    logic [15:0] fm16 [256] = '{default: 16'hFFFF};
    logic we8_q = 1'b1, we16_q = 1'b1;
    int   sts_cnt = 0;
    bit   stuck = 1'b0;
    assign d8   = (!ce8 && !oe8) ? fm8[a8[7:0]] : 'z;
    assign d16  = (!ce16 && !oe16) ? fm16[a16[7:0]] : 'z;
    assign sts8 = !stuck && sts_cnt == 0;
    always @(posedge clk) begin
        if (we8 && !we8_q) begin
            fm8[a8[7:0]] <= d8;
            sts_cnt      <= 20;
        end else if (sts_cnt > 0) sts_cnt <= sts_cnt - 1;
        we8_q <= we8;
        if (we16 && !we16_q) fm16[a16[7:0]] <= d16;
        we16_q <= we16;
    end

    // Transaction-level reference: last value written per address, erased value otherwise.
    logic [7:0]  ref8  [int];
    logic [15:0] ref16 [int];

    int vecs = 0;
    int miss = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic op(input bit w16, input bit wr, input logic [23:0] a, input logic [15:0] d,
                      output logic [15:0] rd, output logic to, output int lat, output int stb,
                      output bit bad);
        bit acc = 1'b0;
        bit got = 1'b0;
        int n = 0;
        logic oe, we;
        if (w16) begin
            b16.cmd_valid = 1'b1; b16.cmd_write = wr; b16.cmd_addr = a; b16.cmd_wdata = d;
        end else begin
            b8.cmd_valid = 1'b1; b8.cmd_write = wr; b8.cmd_addr = a; b8.cmd_wdata = d[7:0];
        end
        while (!acc && n < 100) begin
            acc = w16 ? b16.cmd_ready : b8.cmd_ready;
            tick();
            n++;
        end
        b8.cmd_valid  = 1'b0;
        b16.cmd_valid = 1'b0;
        check("accept", 32'(acc), 32'd1);
        lat = 0; stb = 0; bad = 1'b0;
        while (!got && lat < 6000) begin
            tick();
            lat++;
            oe = w16 ? oe16 : oe8;
            we = w16 ? we16 : we8;
            if (!oe || !we) stb++;
            if ((!oe && !we) || (!oe && wr) || (!we && !wr)) bad = 1'b1;
            got = w16 ? b16.rsp_valid : b8.rsp_valid;
        end
        rd = w16 ? b16.rsp_rdata : {8'h00, b8.rsp_rdata};
        to = w16 ? b16.rsp_timeout : b8.rsp_timeout;
        check("rsp_seen", 32'(got), 32'd1);
        tick();
        check("rsp_pulse", 32'(w16 ? b16.rsp_valid : b8.rsp_valid), 32'd0);
    endtask

    initial begin
        logic [15:0] rd, exp16;
        logic to;
        int lat, stb, n;
        bit bad, seen;
        logic [23:0] a;
        logic [15:0] d;
        bit wr;
        b8.cmd_valid = 0; b8.cmd_write = 0; b8.cmd_addr = 0; b8.cmd_wdata = 0; b8.wp_unlock = 0;
        b16.cmd_valid = 0; b16.cmd_write = 0; b16.cmd_addr = 0; b16.cmd_wdata = 0; b16.wp_unlock = 0;
        repeat (3) tick();
        check("rst_pins", {27'd0, rp8, ce8, oe8, we8, wp8}, 32'b01110);
        check("rst_addr", 32'(a8), 32'd0);
        check("rst_rsp", {29'd0, b8.cmd_ready, b8.rsp_valid, b8.rsp_timeout}, 32'd0);
        check("rst_rdata", 32'(b8.rsp_rdata), 32'd0);
        check("byte_mode", {30'd0, byte8, byte16}, 32'b01);

        b8.wp_unlock = 1'b1;
        b16.wp_unlock = 1'b1;
        rst_n = 1'b1;
        repeat (TRP - 1) tick();
        check("rp_early", {31'd0, rp8}, 32'd0);
        tick();
        check("rp_release", {30'd0, rp8, rp16}, 32'b11);
        check("ready_after_rst", {30'd0, b8.cmd_ready, b16.cmd_ready}, 32'b11);
        check("wp_copy", {31'd0, wp8}, 32'd1);

        op(0, 1, 24'h00000C, 16'h0055, rd, to, lat, stb, bad);
        ref8[12] = 8'h55;
        check("wr_timeout", 32'(to), 32'd0);
        check("wr_we_cycles", 32'(stb), 32'(TP));
        check("wr_sts_lat", 32'(lat > RD_LAT + TBL + 10 && lat < RD_LAT + TBL + 30), 32'd1);
        check("wr_contention", 32'(bad), 32'd0);

        op(0, 0, 24'h00000C, 16'h0000, rd, to, lat, stb, bad);
        check("rd_data", 32'(rd), 32'h55);
        check("rd_latency", 32'(lat), 32'(RD_LAT));
        check("rd_oe_cycles", 32'(stb), 32'(TP));
        check("rd_contention", 32'(bad), 32'd0);

        for (int i = 0; i < 24; i++) begin
            wr = 1'($urandom_range(0, 1));
            a  = 24'($urandom_range(1, 31));
            d  = 16'($urandom);
            op(0, wr, a, d, rd, to, lat, stb, bad);
            check("rnd8_contention", 32'(bad), 32'd0);
            if (wr) begin
                ref8[int'(a)] = d[7:0];
                check("rnd8_wr_timeout", 32'(to), 32'd0);
            end else begin
                check("rnd8_rd_data", 32'(rd), 32'(ref8.exists(int'(a)) ? ref8[int'(a)] : 8'hFF));
                check("rnd8_rd_lat", 32'(lat), 32'(RD_LAT));
            end
        end

        op(1, 1, 24'h000012, 16'hA5C3, rd, to, lat, stb, bad);
        ref16[18] = 16'hA5C3;
        check("w16_wr_lat", 32'(lat), 32'(RD_LAT));
        check("w16_wr_timeout", 32'(to), 32'd0);
        op(1, 0, 24'h000012, 16'h0000, rd, to, lat, stb, bad);
        check("w16_rd_data", 32'(rd), 32'hA5C3);
        check("w16_rd_lat", 32'(lat), 32'(RD_LAT));

        for (int i = 0; i < 16; i++) begin
            wr = 1'($urandom_range(0, 1));
            a  = 24'($urandom_range(1, 31));
            d  = 16'($urandom);
            op(1, wr, a, d, rd, to, lat, stb, bad);
            check("rnd16_contention", 32'(bad), 32'd0);
            check("rnd16_lat", 32'(lat), 32'(RD_LAT));
            exp16 = ref16.exists(int'(a)) ? ref16[int'(a)] : 16'hFFFF;
            if (wr) ref16[int'(a)] = d;
            else check("rnd16_rd_data", 32'(rd), 32'(exp16));
        end

        stuck = 1'b1;
        op(0, 1, 24'h000005, 16'h00C4, rd, to, lat, stb, bad);
        ref8[5] = 8'hC4;
        stuck = 1'b0;
        check("to_flag", 32'(to), 32'd1);
        check("to_latency", 32'(lat), 32'(TS + TP + TH + TBL + TTO + 1));
        check("to_idle", 32'(b8.cmd_ready), 32'd1);

        b8.cmd_valid = 1'b1; b8.cmd_write = 1'b1; b8.cmd_addr = 24'h0000C8; b8.cmd_wdata = 8'h3C;
        tick();
        b8.cmd_valid = 1'b0;
        n = 0;
        while (we8 && n < 20) begin
            tick();
            n++;
        end
        check("abort_in_pulse", {31'd0, we8}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort_pins", {28'd0, we8, ce8, oe8, rp8}, 32'b1110);
        check("abort_rsp", {30'd0, b8.rsp_valid, b8.cmd_ready}, 32'd0);
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < TRP + 4; i++) begin
            tick();
            if (b8.rsp_valid) seen = 1'b1;
        end
        check("abort_no_rsp", 32'(seen), 32'd0);
        check("abort_ready", 32'(b8.cmd_ready), 32'd1);

        op(0, 0, 24'h00000C, 16'h0000, rd, to, lat, stb, bad);
        check("post_rst_rd", 32'(rd), 32'(ref8.exists(12) ? ref8[12] : 8'hFF));
        check("post_rst_lat", 32'(lat), 32'(RD_LAT));
        op(1, 0, 24'h000012, 16'h0000, rd, to, lat, stb, bad);
        check("post_rst_rd16", 32'(rd), 32'(ref16[18]));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
